cmul_rr_sched: RTL

- Time-shares one pipelined Q16.16 complex multiplier between N_REQ requesters using round-robin arbitration.
- Each requester presents one operand pair (a, b) under a valid/ready handshake.
- The scheduler issues at most one product per cycle into a LAT-stage pipeline. It returns the tagged result on a shared response bus.
- Sits between DSP/FFT producer blocks and the complex arithmetic datapath, replacing per-requester multipliers.

---
 rtl/cmul_rr_sched.sv | 317 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/cmul_rr_sched.sv
// ============================================================================
// Module   : cmul_rr_sched
// Purpose  : Round-robin scheduler sharing one pipelined fixed-point complex
//            multiplier (default Q16.16) between N_REQ requesters. At most one
//            operand pair is accepted per cycle; the tagged product comes back
//            LAT cycles after issue on a shared, non-backpressured bus.
//
// Ports    : clk        rising-edge clock
//            rst_n      asynchronous active-low reset
//            en         issue enable (0 blocks grants, pipeline drains)
//            req_valid  per-requester operand valid           [N_REQ]
//            req_ready  per-requester grant, one-hot or zero   [N_REQ]
//            req_a_re/req_a_im/req_b_re/req_b_im
//                       flattened operands, requester i at [i*W +: W]
//            rsp_valid  one-cycle pulse per completed product
//            rsp_id     requester index of the current result
//            rsp_re/rsp_im  product, held while rsp_valid is low
//            busy       any pipeline stage (incl. output) holds an op
//            sat_flag   (CMUL_SAT_EN only) result clamped, pulses with
//                       rsp_valid
//
// Config   : define CMUL_SAT_EN to clamp out-of-range results instead of
//            wrapping and to add the sat_flag output.
//
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmul_rr_sched #(
    parameter int  W     = 32,
    parameter int  FRAC  = 16,
    parameter int  N_REQ = 4,
    parameter int  LAT   = 2,
    localparam int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_a_re,
    input  logic [N_REQ*W-1:0] req_a_im,
    input  logic [N_REQ*W-1:0] req_b_re,
    input  logic [N_REQ*W-1:0] req_b_im,
    output logic               rsp_valid,
    output logic [IDW-1:0]     rsp_id,
    output logic [W-1:0]       rsp_re,
    output logic [W-1:0]       rsp_im,
    output logic               busy
`ifdef CMUL_SAT_EN
    ,
    output logic               sat_flag
`endif
);

    // Number of result-holding stages after the multiplier. With LAT=1 the
    // product is computed straight from the granted operands and lands in
    // the output register; otherwise stage 1 holds operands and the
    // remaining LAT-1 stages hold results, the last being the output.
    localparam int NR = (LAT > 1) ? LAT - 1 : 1;
    // Width of the sign/overflow window of the rounded sum.
    localparam int HB = W - FRAC + 3;

    localparam logic [2*W+1:0] c_round = (2*W+2)'(1) << (FRAC - 1);

    function automatic logic signed [2*W-1:0] sx(input logic [W-1:0] v);
        return {{W{v[W-1]}}, v};
    endfunction

    // ------------------------------------------------------------------
    // Round-robin arbiter
    // ------------------------------------------------------------------
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] w_gidx;
    logic [IDW-1:0] w_next_ptr;
    logic           w_issue;

    // Two passes: first the indices at/above the pointer, then the ones
    // below it, which is the same as an upward search with wrap.
    always_comb begin
        req_ready = '0;
        w_gidx    = '0;
        w_issue   = 1'b0;
        if (en) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (!w_issue && req_valid[j] && (j >= int'(r_ptr))) begin
                    req_ready[j] = 1'b1;
                    w_gidx       = IDW'(j);
                    w_issue      = 1'b1;
                end
            end
            for (int j = 0; j < N_REQ; j++) begin
                if (!w_issue && req_valid[j] && (j < int'(r_ptr))) begin
                    req_ready[j] = 1'b1;
                    w_gidx       = IDW'(j);
                    w_issue      = 1'b1;
                end
            end
        end
    end

    always_comb begin
        if (w_gidx == IDW'(N_REQ - 1)) begin
            w_next_ptr = '0;
        end else begin
            w_next_ptr = w_gidx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_issue) begin
            r_ptr <= w_next_ptr;
        end
    end

    // ------------------------------------------------------------------
    // Operand select for the granted requester
    // ------------------------------------------------------------------
    logic [W-1:0] w_sel_a_re;
    logic [W-1:0] w_sel_a_im;
    logic [W-1:0] w_sel_b_re;
    logic [W-1:0] w_sel_b_im;

    always_comb begin
        w_sel_a_re = '0;
        w_sel_a_im = '0;
        w_sel_b_re = '0;
        w_sel_b_im = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (req_ready[j]) begin
                w_sel_a_re = req_a_re[j*W +: W];
                w_sel_a_im = req_a_im[j*W +: W];
                w_sel_b_re = req_b_re[j*W +: W];
                w_sel_b_im = req_b_im[j*W +: W];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 (operand register) or bypass when LAT == 1
    // ------------------------------------------------------------------
    logic           w_s1_v;
    logic           w_m_v;
    logic [IDW-1:0] w_m_id;
    logic [W-1:0]   w_m_a_re;
    logic [W-1:0]   w_m_a_im;
    logic [W-1:0]   w_m_b_re;
    logic [W-1:0]   w_m_b_im;

    generate
        if (LAT > 1) begin : g_s1
            logic           r_s1_v;
            logic [IDW-1:0] r_s1_id;
            logic [W-1:0]   r_s1_a_re;
            logic [W-1:0]   r_s1_a_im;
            logic [W-1:0]   r_s1_b_re;
            logic [W-1:0]   r_s1_b_im;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_s1_v    <= 1'b0;
                    r_s1_id   <= '0;
                    r_s1_a_re <= '0;
                    r_s1_a_im <= '0;
                    r_s1_b_re <= '0;
                    r_s1_b_im <= '0;
                end else begin
                    r_s1_v <= w_issue;
                    if (w_issue) begin
                        r_s1_id   <= w_gidx;
                        r_s1_a_re <= w_sel_a_re;
                        r_s1_a_im <= w_sel_a_im;
                        r_s1_b_re <= w_sel_b_re;
                        r_s1_b_im <= w_sel_b_im;
                    end
                end
            end

            assign w_s1_v   = r_s1_v;
            assign w_m_v    = r_s1_v;
            assign w_m_id   = r_s1_id;
            assign w_m_a_re = r_s1_a_re;
            assign w_m_a_im = r_s1_a_im;
            assign w_m_b_re = r_s1_b_re;
            assign w_m_b_im = r_s1_b_im;
        end else begin : g_s1_bypass
            assign w_s1_v   = 1'b0;
            assign w_m_v    = w_issue;
            assign w_m_id   = w_gidx;
            assign w_m_a_re = w_sel_a_re;
            assign w_m_a_im = w_sel_a_im;
            assign w_m_b_re = w_sel_b_re;
            assign w_m_b_im = w_sel_b_im;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Complex multiply, round half-up, extract / clamp
    // ------------------------------------------------------------------
    logic signed [2*W-1:0] w_p_rr;
    logic signed [2*W-1:0] w_p_ii;
    logic signed [2*W-1:0] w_p_ri;
    logic signed [2*W-1:0] w_p_ir;
    logic [2*W+1:0]        w_sum_re;
    logic [2*W+1:0]        w_sum_im;
    logic [W-1:0]          w_res_re;
    logic [W-1:0]          w_res_im;
    logic                  w_unused;

    // Sums are carried two bits wider than the product so the difference,
    // the rounding constant and the sign are all exact.
    always_comb begin
        w_p_rr   = sx(w_m_a_re) * sx(w_m_b_re);
        w_p_ii   = sx(w_m_a_im) * sx(w_m_b_im);
        w_p_ri   = sx(w_m_a_re) * sx(w_m_b_im);
        w_p_ir   = sx(w_m_a_im) * sx(w_m_b_re);
        w_sum_re = {{2{w_p_rr[2*W-1]}}, w_p_rr} - {{2{w_p_ii[2*W-1]}}, w_p_ii} + c_round;
        w_sum_im = {{2{w_p_ri[2*W-1]}}, w_p_ri} + {{2{w_p_ir[2*W-1]}}, w_p_ir} + c_round;
        w_res_re = w_sum_re[FRAC+W-1:FRAC];
        w_res_im = w_sum_im[FRAC+W-1:FRAC];
    end

`ifdef CMUL_SAT_EN
    logic         w_ovf_re;
    logic         w_ovf_im;
    logic [W-1:0] w_out_re;
    logic [W-1:0] w_out_im;
    logic         w_m_sat;

    // In range only if every bit from the result MSB upward equals the sign.
    always_comb begin
        w_ovf_re = (w_sum_re[2*W+1:FRAC+W-1] != {HB{w_sum_re[2*W+1]}});
        w_ovf_im = (w_sum_im[2*W+1:FRAC+W-1] != {HB{w_sum_im[2*W+1]}});
        w_out_re = w_res_re;
        w_out_im = w_res_im;
        if (w_ovf_re) begin
            w_out_re = w_sum_re[2*W+1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
        if (w_ovf_im) begin
            w_out_im = w_sum_im[2*W+1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
        w_m_sat = w_ovf_re | w_ovf_im;
    end

    assign w_unused = ^{w_sum_re[FRAC-1:0], w_sum_im[FRAC-1:0]};
`else
    logic [W-1:0] w_out_re;
    logic [W-1:0] w_out_im;

    assign w_out_re = w_res_re;
    assign w_out_im = w_res_im;
    assign w_unused = ^{w_sum_re[FRAC-1:0], w_sum_im[FRAC-1:0],
                        w_sum_re[2*W+1:FRAC+W], w_sum_im[2*W+1:FRAC+W]};
`endif

    // ------------------------------------------------------------------
    // Result stages; the last one drives the response bus. Data only
    // loads with a valid op so the outputs hold between pulses.
    // ------------------------------------------------------------------
    logic [NR-1:0]  r_pv;
    logic [IDW-1:0] r_pid [NR];
    logic [W-1:0]   r_pre [NR];
    logic [W-1:0]   r_pim [NR];
`ifdef CMUL_SAT_EN
    logic [NR-1:0]  r_psat;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pv <= '0;
`ifdef CMUL_SAT_EN
            r_psat <= '0;
`endif
            for (int i = 0; i < NR; i++) begin
                r_pid[i] <= '0;
                r_pre[i] <= '0;
                r_pim[i] <= '0;
            end
        end else begin
            r_pv[0] <= w_m_v;
            if (w_m_v) begin
                r_pid[0] <= w_m_id;
                r_pre[0] <= w_out_re;
                r_pim[0] <= w_out_im;
`ifdef CMUL_SAT_EN
                r_psat[0] <= w_m_sat;
`endif
            end
            for (int i = 1; i < NR; i++) begin
                r_pv[i] <= r_pv[i-1];
                if (r_pv[i-1]) begin
                    r_pid[i] <= r_pid[i-1];
                    r_pre[i] <= r_pre[i-1];
                    r_pim[i] <= r_pim[i-1];
`ifdef CMUL_SAT_EN
                    r_psat[i] <= r_psat[i-1];
`endif
                end
            end
        end
    end

    assign rsp_valid = r_pv[NR-1];
    assign rsp_id    = r_pid[NR-1];
    assign rsp_re    = r_pre[NR-1];
    assign rsp_im    = r_pim[NR-1];
    assign busy      = w_s1_v | (|r_pv);
`ifdef CMUL_SAT_EN
    // Stored flag is held with the data, so gate it to a single pulse.
    assign sat_flag  = r_pv[NR-1] & r_psat[NR-1];
`endif

endmodule

`default_nettype wire
